imem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data block RAM between three requesters:
  - the UART program loader (LD), write-only;
  - the load/store unit (DM), read/write;
  - the instruction fetch stage (IF), read-only.
- Issues at most one RAM access per cycle and returns read data one cycle later, matching the RAM's 1-cycle synchronous read latency.
- Provides a stall signal so the PC does not advance while the fetch is not granted.

---
 rtl/cpu_mem_pkg.sv | 14 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/imem_port_arbiter.sv | 113 +++++++++++
 tb/tb_imem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: word width, default RAM address
// width and the read-owner tag used by the block RAM port arbiter.
package cpu_mem_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned ADDR_W_DEF = 14;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DM   = 2'd1,
      OWN_IF   = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; force_o raises the
// fetch to top priority once the limit is reached.
module arb_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic reset,
   input  logic if_req_i,
   input  logic if_gnt_i,
   output logic force_o
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (reset || !if_req_i || if_gnt_i) begin
         cnt <= '0;
      end else if (cnt != LIMIT) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign force_o = (cnt == LIMIT);

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port block RAM arbiter for loader, load/store unit and fetch, with
// fetch starvation protection and 1-cycle read return to the owning requester.
module imem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              ld_req_i,
   input  logic [31:0]       ld_addr_i,
   input  logic [31:0]       ld_wdata_i,
   output logic              ld_gnt_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [31:0]       dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [31:0]       dm_rdata_o,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   output logic              if_stall_o,
   output logic              addr_err_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   logic              starve_force;
   logic              gnt_ld, gnt_dm, gnt_if;
   logic              any_gnt, wr_gnt, rd_gnt, addr_ok;
   logic [WORD_W-1:0] sel_addr, sel_wdata;
   owner_e            owner_q;
   logic              rd_err_q, addr_err_q;

   arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk_i   (clk_i),
      .reset   (reset),
      .if_req_i(if_req_i),
      .if_gnt_i(gnt_if),
      .force_o (starve_force)
   );

   always_comb begin
      gnt_ld = 1'b0;
      gnt_dm = 1'b0;
      gnt_if = 1'b0;
      if (!reset) begin
         if (if_req_i && starve_force) gnt_if = 1'b1;
         else if (ld_req_i)            gnt_ld = 1'b1;
         else if (dm_req_i)            gnt_dm = 1'b1;
         else if (if_req_i)            gnt_if = 1'b1;
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt_ld) begin
         sel_addr  = ld_addr_i;
         sel_wdata = ld_wdata_i;
      end else if (gnt_dm) begin
         sel_addr  = dm_addr_i;
         sel_wdata = dm_wdata_i;
      end else if (gnt_if) begin
         sel_addr  = if_addr_i;
      end
   end

   assign any_gnt = gnt_ld | gnt_dm | gnt_if;
   assign wr_gnt  = gnt_ld | (gnt_dm & dm_we_i);
   assign rd_gnt  = (gnt_dm & ~dm_we_i) | gnt_if;
   assign addr_ok = (sel_addr[1:0] == 2'b00) && (sel_addr[31:ADDR_W+2] == '0);

   assign ram_addr_o  = sel_addr[ADDR_W+1:2];
   assign ram_we_o    = wr_gnt & addr_ok;
   assign ram_wdata_o = sel_wdata;

   assign ld_gnt_o   = gnt_ld;
   assign dm_gnt_o   = gnt_dm;
   assign if_gnt_o   = gnt_if;
   assign if_stall_o = if_req_i & ~gnt_if;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         rd_err_q   <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         if (gnt_dm && !dm_we_i) owner_q <= OWN_DM;
         else if (gnt_if)        owner_q <= OWN_IF;
         else                    owner_q <= OWN_NONE;
         rd_err_q   <= rd_gnt & ~addr_ok;
         addr_err_q <= any_gnt & ~addr_ok;
      end
   end

   // Gating with reset hides a read tag captured on the edge just before reset.
   assign dm_rvalid_o = ~reset && (owner_q == OWN_DM);
   assign if_rvalid_o = ~reset && (owner_q == OWN_IF);
   assign dm_rdata_o  = (dm_rvalid_o && !rd_err_q) ? ram_rdata_i : '0;
   assign if_rdata_o  = (if_rvalid_o && !rd_err_q) ? ram_rdata_i : '0;
   assign addr_err_o  = addr_err_q & ~reset;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed plus random check of imem_port_arbiter against a cycle-level
// behavioural model (priority rules, starvation count, shadow memory).
module tb_imem_port_arbiter;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned LIMIT  = 4;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic        clk_i = 1'b0;
   logic        reset = 1'b1;
   logic        ld_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, if_req = 1'b0;
   logic [31:0] ld_addr = '0, ld_wdata = '0, dm_addr = '0, dm_wdata = '0, if_addr = '0;
   logic        ld_gnt, dm_gnt, dm_rvalid, if_gnt, if_rvalid, if_stall, addr_err;
   logic [31:0] dm_rdata, if_rdata, ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic        ram_we;

   logic [31:0] mem [DEPTH];
   logic        mem_clr = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model state
   int          starve = 0;
   bit          exp_dm_rv = 0, exp_if_rv = 0, exp_err = 0;
   logic [31:0] exp_dm_rd = '0, exp_if_rd = '0;
   logic [31:0] shadow [int unsigned];
   logic        last_if_gnt;

   always #5 clk_i = ~clk_i;

   imem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_i      (clk_i),
      .reset      (reset),
      .ld_req_i   (ld_req),
      .ld_addr_i  (ld_addr),
      .ld_wdata_i (ld_wdata),
      .ld_gnt_o   (ld_gnt),
      .dm_req_i   (dm_req),
      .dm_we_i    (dm_we),
      .dm_addr_i  (dm_addr),
      .dm_wdata_i (dm_wdata),
      .dm_gnt_o   (dm_gnt),
      .dm_rvalid_o(dm_rvalid),
      .dm_rdata_o (dm_rdata),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_gnt_o   (if_gnt),
      .if_rvalid_o(if_rvalid),
      .if_rdata_o (if_rdata),
      .if_stall_o (if_stall),
      .addr_err_o (addr_err),
      .ram_addr_o (ram_addr),
      .ram_we_o   (ram_we),
      .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata)
   );

   // single-port synchronous RAM, read-first
   always @(posedge clk_i) begin
      if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ram_rdata <= '0;
      end else begin
         ram_rdata <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= ram_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] shadow_rd(input int unsigned w);
      return shadow.exists(w) ? shadow[w] : 32'h0;
   endfunction

   task automatic check_returns();
      chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_rv));
      chk("dm_rdata",  dm_rdata,       exp_dm_rd);
      chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
      chk("if_rdata",  if_rdata,       exp_if_rd);
      chk("addr_err",  32'(addr_err),  32'(exp_err));
   endtask

   // One arbitration cycle: drive, check at the falling edge, advance model.
   task automatic step(input bit lr, input logic [31:0] la, input logic [31:0] lw,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                       input bit ir, input logic [31:0] ia);
      int          win;
      bit          ok, we, rd;
      logic [31:0] a, wd;
      int unsigned w;
      ld_req = lr; ld_addr = la; ld_wdata = lw;
      dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
      if_req = ir; if_addr = ia;
      @(negedge clk_i);
      if (ir && starve == LIMIT) win = 3;
      else if (lr)               win = 1;
      else if (dr)               win = 2;
      else if (ir)               win = 3;
      else                       win = 0;
      a  = (win == 1) ? la : (win == 2) ? da : (win == 3) ? ia : 32'h0;
      wd = (win == 1) ? lw : dwd;
      ok = (a % 4 == 0) && (a < (32'd4 << ADDR_W));
      we = (win == 1 || (win == 2 && dw)) && ok;
      rd = (win == 2 && !dw) || win == 3;
      w  = (a / 4) % DEPTH;
      chk("ld_gnt",   32'(ld_gnt),   32'(win == 1));
      chk("dm_gnt",   32'(dm_gnt),   32'(win == 2));
      chk("if_gnt",   32'(if_gnt),   32'(win == 3));
      chk("if_stall", 32'(if_stall), 32'(ir && win != 3));
      chk("ram_we",   32'(ram_we),   32'(we));
      chk("ram_addr", 32'(ram_addr), w);
      if (we) chk("ram_wdata", ram_wdata, wd);
      check_returns();
      last_if_gnt = if_gnt;
      @(posedge clk_i);
      #1;
      if (we) shadow[w] = wd;
      exp_dm_rv = (win == 2) && rd;
      exp_if_rv = (win == 3);
      exp_dm_rd = (exp_dm_rv && ok) ? shadow_rd(w) : 32'h0;
      exp_if_rd = (exp_if_rv && ok) ? shadow_rd(w) : 32'h0;
      exp_err   = (win != 0) && !ok;
      if (!ir || win == 3) starve = 0;
      else if (starve < LIMIT) starve++;
   endtask

   task automatic reset_cycle(input bit with_reqs);
      reset  = 1'b1;
      ld_req = with_reqs; dm_req = with_reqs; dm_we = 1'b0; if_req = with_reqs;
      ld_addr = 32'h4; dm_addr = 32'h8; if_addr = 32'hC;
      @(negedge clk_i);
      chk("rst_ld_gnt",   32'(ld_gnt),    32'h0);
      chk("rst_dm_gnt",   32'(dm_gnt),    32'h0);
      chk("rst_if_gnt",   32'(if_gnt),    32'h0);
      chk("rst_if_stall", 32'(if_stall),  32'(with_reqs));
      chk("rst_ram_we",   32'(ram_we),    32'h0);
      chk("rst_ram_addr", 32'(ram_addr),  32'h0);
      chk("rst_dm_rv",    32'(dm_rvalid), 32'h0);
      chk("rst_if_rv",    32'(if_rvalid), 32'h0);
      chk("rst_dm_rd",    dm_rdata,       32'h0);
      chk("rst_if_rd",    if_rdata,       32'h0);
      chk("rst_addr_err", 32'(addr_err),  32'h0);
      @(posedge clk_i);
      #1;
      starve = 0;
      exp_dm_rv = 0; exp_if_rv = 0; exp_err = 0;
      exp_dm_rd = '0; exp_if_rd = '0;
   endtask

   initial begin
      logic [31:0] ra;
      bit          r_lr, r_dr, r_dw, r_ir;

      // power-up reset, RAM cleared
      reset_cycle(1'b0);
      reset_cycle(1'b1);
      mem_clr = 1'b0;
      reset   = 1'b0;

      // preload words 0..2 through the loader port
      step(1, 32'h0, 32'h11, 0, 0, 0, 0, 0, 0);
      step(1, 32'h4, 32'h22, 0, 0, 0, 0, 0, 0);
      step(1, 32'h8, 32'h33, 0, 0, 0, 0, 0, 0);

      // back-to-back fetches 0x0, 0x4, 0x8
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h4);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fetch_tail", 32'(last_if_gnt), 32'h0);

      // store wins over fetch, fetch follows, load reads the stored word
      step(0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'hC);
      chk("store_blocks_if", 32'(last_if_gnt), 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'hC);
      chk("if_after_store", 32'(last_if_gnt), 32'h1);
      step(0, 0, 0, 1, 0, 32'h40, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // starvation: fetch granted every fifth cycle under LD+DM pressure
      for (int i = 0; i < 10; i++) begin
         step(1, 32'h80 + 32'(i) * 4, 32'(i), 1, 1, 32'h100, 32'hA5A5_0000 + 32'(i), 1, 32'h10);
         chk("starve_pattern", 32'(last_if_gnt), 32'(i % 5 == 4));
      end

      // misaligned store, out-of-range load
      step(0, 0, 0, 1, 1, 32'h42, 32'hCAFEF00D, 0, 0);
      step(0, 0, 0, 1, 0, 32'h0010_0000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'h40, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // reset right after a fetch grant drops the pending return
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      reset_cycle(1'b0);
      reset_cycle(1'b1);
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // idle
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic over a small window with occasional bad addresses
      for (int i = 0; i < 400; i++) begin
         r_lr = ($urandom_range(3) == 0);
         r_dr = ($urandom_range(1) == 0);
         r_dw = ($urandom_range(1) == 0);
         r_ir = ($urandom_range(3) != 0);
         ra = 32'($urandom_range(31)) * 4;
         if ($urandom_range(15) == 0) ra = ra + 32'($urandom_range(3, 1));
         if ($urandom_range(15) == 0) ra = ra | 32'h0004_0000;
         step(r_lr, 32'($urandom_range(31)) * 4, $urandom,
              r_dr, r_dw, ra, $urandom,
              r_ir, 32'($urandom_range(31)) * 4);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
